packet_framer: RTL and testbench

- Upstream stage of `transmitter`. Accepts 32-bit payload words over a valid/ready handshake.
- Computes CRC-8 bit-serially and builds the 48-bit frame `{HEADER, payload, crc8}` on `data2send`.
- Pulses the transmitter `start`, then tracks `err_code` until ACK. Retries on NAK or timeout.
- Reports a per-word `done` or `fail` to the application.

---
 rtl/framer_pkg.sv | 32 +++
 rtl/crc8_serial.sv | 45 ++++
 rtl/packet_framer.sv | 189 ++++++++++++++++++
 tb/tb_packet_framer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/framer_pkg.sv
// framer_pkg: shared types and constants for the packet framer and its
// receiver-side counterpart.
//   err_code_t  - transmitter status encoding seen on err_code
//   fsm_state_t - framer control states
//   HEADER_DEFAULT / POLY_DEFAULT - default frame header and CRC-8 polynomial
//   N_PKT / N_DATA - frame and payload widths in bits
package framer_pkg;

  typedef enum logic [1:0] {
    ACK  = 2'b00,
    NAK  = 2'b01,
    TMO  = 2'b10,
    BUSY = 2'b11
  } err_code_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CRC        = 3'd1,
    WAIT_AVAIL = 3'd2,
    START      = 3'd3,
    WAIT_BUSY  = 3'd4,
    WAIT_DONE  = 3'd5,
    RESULT     = 3'd6
  } fsm_state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'h3c;
  localparam logic [7:0] POLY_DEFAULT   = 8'h07;

  localparam int N_PKT  = 48;
  localparam int N_DATA = 32;

endpackage

// File: rtl/crc8_serial.sv
// crc8_serial: bit-serial CRC-8, MSB first, no reflection, no final XOR.
// Ports:
//   clk    - clock
//   rst    - synchronous active-high reset (crc -> 0)
//   clr    - synchronous clear to the 8'h00 init value
//   en     - advance the CRC by one bit
//   bit_in - data bit consumed when en is high
//   crc    - current CRC register value
module crc8_serial #(
  parameter logic [7:0] POLY = 8'h07
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;
  logic       fb_d;

  assign fb_d = crc_q[7] ^ bit_in;

  // Shift left by one and fold the feedback bit into the polynomial taps.
  for (genvar gi = 0; gi < 8; gi++) begin : g_crc_bit
    if (gi == 0) begin : g_lsb
      assign crc_d[gi] = fb_d & POLY[gi];
    end else begin : g_upper
      assign crc_d[gi] = crc_q[gi-1] ^ (fb_d & POLY[gi]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc_q <= 8'h00;
    end else if (en) begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/packet_framer.sv
// packet_framer: accepts 32-bit payload words, appends a header and CRC-8,
// hands the 48-bit frame to the transmitter and retries on NAK/timeout.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_data/in_valid     - payload word and its valid
//   in_ready             - high only while idle and able to accept a word
//   data2send            - {HEADER, payload, crc8} frame for the transmitter
//   start                - one-cycle transmit request
//   avail                - transmitter ready for a new request
//   err_code             - transmitter status (ACK/NAK/TMO/BUSY)
//   done / fail          - one-cycle per-word outcome pulses
//   retries              - re-sends used for the current or last word
module packet_framer
  import framer_pkg::*;
#(
  parameter logic [7:0]  HEADER    = HEADER_DEFAULT,
  parameter logic [7:0]  POLY      = POLY_DEFAULT,
  parameter int unsigned MAX_RETRY = 3,
  parameter logic [31:0] WDOG      = 32'h00ff_ffff
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_DATA-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N_PKT-1:0]   data2send,
  output logic               start,
  input  logic               avail,
  input  logic [1:0]         err_code,
  output logic               done,
  output logic               fail,
  output logic [1:0]         retries
);

  localparam logic [1:0] MAX_RETRY_W = 2'(MAX_RETRY);

  fsm_state_t          state_q;
  logic [N_DATA-1:0]   payload_q;
  logic [4:0]          bit_cnt_q;
  logic [31:0]         wdog_q;
  logic                load_frame_q;
  logic [1:0]          retries_q;
  logic                in_ready_q;
  logic                start_q;
  logic                done_q;
  logic                fail_q;
  logic [N_PKT-1:0]    data2send_q;

  logic                accept_d;
  logic                in_wait_d;
  logic                wdog_hit_d;
  logic                crc_bit_d;
  err_code_t           err_d;
  logic [7:0]          crc_w;

  assign err_d     = err_code_t'(err_code);
  assign accept_d  = (state_q == IDLE) && in_valid && in_ready_q;
  assign in_wait_d = (state_q == WAIT_AVAIL) || (state_q == WAIT_BUSY) ||
                     (state_q == WAIT_DONE);
  // Counter starts at 0 on state entry, so the state is left after WDOG cycles.
  assign wdog_hit_d = in_wait_d && (wdog_q >= (WDOG - 32'd1));
  // ~bit_cnt_q == 31 - bit_cnt_q: MSB of the payload goes first.
  assign crc_bit_d = payload_q[~bit_cnt_q];

  crc8_serial #(
    .POLY (POLY)
  ) u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept_d),
    .en     (state_q == CRC),
    .bit_in (crc_bit_d),
    .crc    (crc_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      payload_q    <= '0;
      bit_cnt_q    <= '0;
      wdog_q       <= '0;
      load_frame_q <= 1'b0;
      retries_q    <= '0;
      in_ready_q   <= 1'b0;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      data2send_q  <= '0;
    end else begin
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      load_frame_q <= 1'b0;
      wdog_q       <= in_wait_d ? wdog_q + 32'd1 : 32'd0;

      // The CRC register absorbs the last bit on the CRC exit edge, so the
      // frame is captured one cycle later. Retries never reload it.
      if (load_frame_q) begin
        data2send_q <= {HEADER, payload_q, crc_w};
      end

      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (accept_d) begin
            payload_q  <= in_data;
            retries_q  <= '0;
            bit_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CRC;
          end
        end

        CRC: begin
          bit_cnt_q <= bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd31) begin
            load_frame_q <= 1'b1;
            wdog_q       <= '0;
            state_q      <= WAIT_AVAIL;
          end
        end

        WAIT_AVAIL: begin
          if (avail) begin
            start_q <= 1'b1;
            wdog_q  <= '0;
            state_q <= START;
          end else if (wdog_hit_d) begin
            wdog_q  <= '0;
            state_q <= RESULT;
          end
        end

        START: begin
          wdog_q  <= '0;
          state_q <= WAIT_BUSY;
        end

        // Require BUSY first so a leftover ACK from the previous word is
        // not mistaken for this attempt's result.
        WAIT_BUSY: begin
          if (err_d == BUSY) begin
            wdog_q  <= '0;
            state_q <= WAIT_DONE;
          end else if (wdog_hit_d) begin
            wdog_q  <= '0;
            state_q <= RESULT;
          end
        end

        WAIT_DONE: begin
          if (err_d == ACK) begin
            done_q     <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
          end else if (err_d != BUSY || wdog_hit_d) begin
            wdog_q  <= '0;
            state_q <= RESULT;
          end
        end

        RESULT: begin
          if (retries_q < MAX_RETRY_W) begin
            retries_q <= retries_q + 2'd1;
            wdog_q    <= '0;
            state_q   <= WAIT_AVAIL;
          end else begin
            fail_q     <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end

        default: begin
          in_ready_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign data2send = data2send_q;
  assign start     = start_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign retries   = retries_q;

endmodule

// File: tb/tb_packet_framer.sv
// Testbench for packet_framer with a small transmitter model and a
// scoreboard of expected per-word outcomes.
module tb_packet_framer;
  import framer_pkg::*;

  localparam logic [31:0] WDOG_TB = 32'd100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] data2send;
  logic        start;
  logic        avail;
  logic [1:0]  err_code;
  logic        done;
  logic        fail;
  logic [1:0]  retries;

  packet_framer #(
    .HEADER    (8'h3c),
    .POLY      (8'h07),
    .MAX_RETRY (3),
    .WDOG      (WDOG_TB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data2send (data2send),
    .start     (start),
    .avail     (avail),
    .err_code  (err_code),
    .done      (done),
    .fail      (fail),
    .retries   (retries)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference CRC-8, MSB first, init 0, poly 0x07.
  function automatic logic [7:0] crc8_ref(input logic [31:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  typedef struct {
    logic [31:0] word;
    logic [47:0] frame;
    logic        exp_done;
    logic [1:0]  exp_retries;
    int          exp_starts;
  } sb_t;

  sb_t sb_q[$];
  sb_t sb_e;

  // Transmitter model controls
  int nak_limit  = 0;
  bit stuck_busy = 1'b0;
  int attempts   = 0;

  // Monitor bookkeeping
  int start_cnt       = 0;
  int first_start_cyc = 0;
  int prev_start_cyc  = 0;
  int last_start_cyc  = 0;
  int accept_cyc      = 0;
  int ready_viol      = 0;
  bit in_flight       = 1'b0;

  // Transmitter model: status stays stale for one cycle after start, then
  // BUSY for a few cycles, then NAK for the first nak_limit attempts, else ACK.
  initial begin
    avail    = 1'b1;
    err_code = ACK;
    forever begin
      @(negedge clk);
      if (!rst && start === 1'b1) begin
        attempts++;
        @(negedge clk);
        err_code = BUSY;
        if (!stuck_busy) begin
          repeat (3) @(negedge clk);
          err_code = (attempts <= nak_limit) ? NAK : ACK;
        end
      end
    end
  end

  // Output monitor / scoreboard checker
  always @(negedge clk) begin
    if (!rst) begin
      if (start === 1'b1) begin
        if (sb_q.size() > 0) check_val("start_frame", data2send, sb_q[0].frame);
        else                 check_val("unexpected_start", start, 1'b0);
        if (start_cnt == 0) first_start_cyc = cyc;
        prev_start_cyc = last_start_cyc;
        last_start_cyc = cyc;
        start_cnt++;
      end
      if (in_flight && in_ready === 1'b1 && !done && !fail) ready_viol++;
      if (done === 1'b1 || fail === 1'b1) begin
        check_val("done_fail_exclusive", done & fail, 1'b0);
        if (sb_q.size() == 0) begin
          check_val("unexpected_result", {done, fail}, 2'b00);
        end else begin
          sb_e = sb_q.pop_front();
          check_val("outcome_done", done, sb_e.exp_done);
          check_val("outcome_fail", fail, !sb_e.exp_done);
          check_val("retries", retries, sb_e.exp_retries);
          check_val("start_count", start_cnt, sb_e.exp_starts);
          check_val("ready_with_result", in_ready, 1'b1);
          check_val("ready_low_while_busy", ready_viol, 0);
          check_val("frame_held", data2send, sb_e.frame);
          $display("word %08h frame %012h done=%0d fail=%0d retries=%0d starts=%0d",
                   sb_e.word, data2send, done, fail, retries, start_cnt);
        end
        in_flight = 1'b0;
      end
    end
  end

  task automatic accept_word(input logic [31:0] w, input logic [47:0] frame,
                             input int naks, input bit stuck, input bit hold_valid,
                             input logic exp_done, input logic [1:0] exp_ret,
                             input int exp_starts);
    int budget;
    nak_limit  = naks;
    stuck_busy = stuck;
    attempts   = 0;
    start_cnt  = 0;
    ready_viol = 0;
    budget = 0;
    while (in_ready !== 1'b1 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check_val("ready_before_accept", in_ready, 1'b1);
    in_data  = w;
    in_valid = 1'b1;
    sb_q.push_back('{w, frame, exp_done, exp_ret, exp_starts});
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    in_flight  = 1'b1;
    // Keep presenting a different word while busy; it must be ignored.
    if (hold_valid) begin
      in_data = ~w;
      repeat (20) @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result();
    int budget;
    budget = 0;
    while (sb_q.size() > 0 && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    check_val("result_timeout", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic send_word(input logic [31:0] w, input logic [47:0] frame,
                           input int naks, input bit stuck, input bit hold_valid,
                           input logic exp_done, input logic [1:0] exp_ret,
                           input int exp_starts);
    accept_word(w, frame, naks, stuck, hold_valid, exp_done, exp_ret, exp_starts);
    wait_result();
  endtask

  logic [31:0] w_rand;
  int          naks_rand;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", in_ready, 1'b0);
    check_val("rst_data2send", data2send, 48'h0);
    check_val("rst_start", start, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_fail", fail, 1'b0);
    check_val("rst_retries", retries, 2'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("ready_after_rst", in_ready, 1'b1);

    // Zero word, ideal transmitter: start lands on cycle 34 counting the
    // accept edge as the start of cycle 1 (32 CRC + WAIT_AVAIL + START).
    send_word(32'h0000_0000, 48'h3c_0000_0000_00, 0, 1'b0, 1'b0, 1'b1, 2'd0, 1);
    check_val("start_latency", first_start_cyc - accept_cyc, 33);

    // Known CRC vector, with in_valid held high while busy.
    send_word(32'h1234_5678, 48'h3c_1234_5678_1c, 0, 1'b0, 1'b1, 1'b1, 2'd0, 1);

    // Two NAKs then ACK.
    send_word(32'h1234_5678, 48'h3c_1234_5678_1c, 2, 1'b0, 1'b0, 1'b1, 2'd2, 3);
    @(negedge clk);
    check_val("retries_hold", retries, 2'd2);

    // Always NAK: first attempt plus 3 retries, then fail.
    w_rand = 32'hdead_beef;
    send_word(w_rand, {8'h3c, w_rand, crc8_ref(w_rand)}, 99, 1'b0, 1'b0, 1'b0, 2'd3, 4);

    // err_code stuck at BUSY: each attempt ends on the watchdog. Between
    // starts: START, WAIT_BUSY, WDOG cycles of WAIT_DONE, RESULT, WAIT_AVAIL.
    w_rand = 32'h0f0f_a5a5;
    send_word(w_rand, {8'h3c, w_rand, crc8_ref(w_rand)}, 0, 1'b1, 1'b0, 1'b0, 2'd3, 4);
    check_val("wdog_retry_gap", last_start_cyc - prev_start_cyc, 32'(WDOG_TB) + 4);

    // Reset while waiting in WAIT_DONE.
    w_rand = 32'hcafe_f00d;
    accept_word(w_rand, {8'h3c, w_rand, crc8_ref(w_rand)}, 0, 1'b1, 1'b0, 1'b1, 2'd0, 1);
    begin
      int budget;
      budget = 0;
      while (start_cnt == 0 && budget < 100) begin
        @(negedge clk);
        budget++;
      end
      check_val("start_before_reset", start_cnt, 1);
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("midrst_in_ready", in_ready, 1'b0);
    check_val("midrst_data2send", data2send, 48'h0);
    check_val("midrst_start", start, 1'b0);
    check_val("midrst_done", done, 1'b0);
    check_val("midrst_fail", fail, 1'b0);
    check_val("midrst_retries", retries, 2'd0);
    sb_q.delete();
    in_flight  = 1'b0;
    stuck_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    start_cnt = 0;
    @(negedge clk);
    check_val("ready_after_midrst", in_ready, 1'b1);
    repeat (150) @(negedge clk);
    check_val("no_start_after_rst", start_cnt, 0);

    // Normal operation after the abort, then a few random words.
    w_rand = 32'h8000_0001;
    send_word(w_rand, {8'h3c, w_rand, crc8_ref(w_rand)}, 0, 1'b0, 1'b0, 1'b1, 2'd0, 1);
    for (int i = 0; i < 4; i++) begin
      w_rand    = $urandom;
      naks_rand = $urandom_range(0, 3);
      send_word(w_rand, {8'h3c, w_rand, crc8_ref(w_rand)}, naks_rand, 1'b0, 1'b0,
                1'b1, 2'(naks_rand), naks_rand + 1);
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
